data_memory_sync: RTL and testbench

//  Parametrised data memory for the MEM stage of the pipeline; next generation of the 8-bit data RAM.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/data_memory_sync_if.sv | 32 +++
 rtl/dmem_sram_array.sv | 38 +++
 rtl/data_memory_sync.sv | 110 +++++++++++
 tb/tb_data_memory_sync.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the pipeline data memory.
//   state_e           controller state: CLEAR sweeps zeros into every word, READY serves requests
//   DefaultDataWidth  default word width in bits
//   DefaultAddrLine   default address bus width
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultAddrLine  = 8;

endpackage

// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the MEM stage and the data memory.
//   write_data  store data                  (master -> slave)
//   address     word address                (master -> slave)
//   mem_write   store request               (master -> slave)
//   mem_read    load request                (master -> slave)
//   read_data   registered load data        (slave -> master)
//   read_valid  read_data holds a result    (slave -> master)
//   busy        clear sweep in progress     (slave -> master)
//   addr_error  last request was out of range (slave -> master)
interface data_memory_sync_if #(
    parameter int unsigned DATA_WIDTH   = dmem_pkg::DefaultDataWidth,
    parameter int unsigned ADDRESS_LINE = dmem_pkg::DefaultAddrLine
);
    logic [DATA_WIDTH-1:0]   write_data;
    logic [ADDRESS_LINE-1:0] address;
    logic                    mem_write;
    logic                    mem_read;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_valid;
    logic                    busy;
    logic                    addr_error;

    modport master (
        output write_data, address, mem_write, mem_read,
        input  read_data, read_valid, busy, addr_error
    );

    modport slave (
        input  write_data, address, mem_write, mem_read,
        output read_data, read_valid, busy, addr_error
    );
endinterface

// File: rtl/dmem_sram_array.sv
// Storage for the data memory: one write port, one synchronous read port, no reset.
// A read and a write to the same word in one cycle return the new data (write-first).
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address (must be < DEPTH when we_i is set)
//   wdata_i  write data
//   re_i     read enable; rdata_o holds its value otherwise
//   raddr_i  read address (must be < DEPTH when re_i is set)
//   rdata_o  registered read data
module dmem_sram_array #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDRESS_LINE = 8,
    parameter int unsigned DEPTH        = 2 ** ADDRESS_LINE
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [ADDRESS_LINE-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_i,
    input  logic [ADDRESS_LINE-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// MEM-stage data memory with registered read, write-first bypass, address range checking and a
// sequenced post-reset clear (one word per cycle) during which busy stalls the pipeline.
//   clock   single clock, all state on posedge
//   reset   synchronous, active-high; dominates every request
//   bus_io  request/response bundle (slave side): write_data, address, mem_write, mem_read in;
//           read_data, read_valid, busy, addr_error out
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
    parameter int unsigned ADDRESS_LINE   = DefaultAddrLine,
    parameter int unsigned DEPTH          = 2 ** ADDRESS_LINE,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    data_memory_sync_if.slave bus_io
);

    // One extra bit so DEPTH == 2**ADDRESS_LINE is representable.
    localparam logic [ADDRESS_LINE:0]   DepthExt = (ADDRESS_LINE + 1)'(DEPTH);
    localparam logic [ADDRESS_LINE-1:0] LastPtr  = ADDRESS_LINE'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDRESS_LINE-1:0] clear_ptr_q, clear_ptr_d;
    logic                    read_valid_q, read_valid_d;
    logic                    read_hit_q, read_hit_d;
    logic                    addr_error_q, addr_error_d;

    logic                    in_range;
    logic                    ram_we;
    logic [ADDRESS_LINE-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign in_range = {1'b0, bus_io.address} < DepthExt;

    always_comb begin
        state_d      = state_q;
        clear_ptr_d  = clear_ptr_q;
        read_valid_d = 1'b0;
        read_hit_d   = 1'b0;
        addr_error_d = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = bus_io.address;
        ram_wdata    = bus_io.write_data;
        ram_re       = 1'b0;

        case (state_q)
            CLEAR: begin
                ram_we      = !reset;
                ram_waddr   = clear_ptr_q;
                ram_wdata   = '0;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LastPtr) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!reset) begin
                    ram_we       = bus_io.mem_write && in_range;
                    ram_re       = bus_io.mem_read && in_range;
                    read_valid_d = bus_io.mem_read;
                    // Out-of-range reads still complete, but with zero data.
                    read_hit_d   = bus_io.mem_read && in_range;
                    addr_error_d = (bus_io.mem_read || bus_io.mem_write) && !in_range;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : READY;
            clear_ptr_q  <= '0;
            read_valid_q <= 1'b0;
            read_hit_q   <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_ptr_q  <= clear_ptr_d;
            read_valid_q <= read_valid_d;
            read_hit_q   <= read_hit_d;
            addr_error_q <= addr_error_d;
        end
    end

    dmem_sram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDRESS_LINE(ADDRESS_LINE),
        .DEPTH       (DEPTH)
    ) u_array (
        .clk_i  (clock),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .re_i   (ram_re),
        .raddr_i(bus_io.address),
        .rdata_o(ram_rdata)
    );

    // The array keeps its last read value; mask it so idle cycles never show stale data.
    assign bus_io.read_data  = read_hit_q ? ram_rdata : '0;
    assign bus_io.read_valid = read_valid_q;
    assign bus_io.busy       = (state_q == CLEAR);
    assign bus_io.addr_error = addr_error_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: instance A (DEPTH=20, clear on reset) and instance B
// (DEPTH=32, no clear) share clock and reset. A behavioural model tracks both and is compared
// every cycle; directed tests add literal expectations.
module tb_data_memory_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_memory_sync_if #(.DATA_WIDTH(8), .ADDRESS_LINE(5)) ifa ();
    data_memory_sync_if #(.DATA_WIDTH(8), .ADDRESS_LINE(5)) ifb ();

    data_memory_sync #(
        .DATA_WIDTH(8), .ADDRESS_LINE(5), .DEPTH(20), .CLEAR_ON_RESET(1'b1)
    ) u_a (
        .clock (clk),
        .reset (rst),
        .bus_io(ifa.slave)
    );

    data_memory_sync #(
        .DATA_WIDTH(8), .ADDRESS_LINE(5), .DEPTH(32), .CLEAR_ON_RESET(1'b0)
    ) u_b (
        .clock (clk),
        .reset (rst),
        .bus_io(ifb.slave)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem   [2][32];
    bit         m_known [2][32];
    int         m_left  [2];
    bit         m_valid [2] = '{1'b0, 1'b0};
    logic [7:0] e_rd    [2];
    bit         e_rv    [2];
    bit         e_err   [2];
    bit         e_rdk   [2];

    task automatic model_step(input int k, input bit r, input bit we, input bit re,
                              input logic [4:0] addr, input logic [7:0] wd);
        int  dep;
        bit  clr;
        bit  inr;
        dep = (k == 0) ? 20 : 32;
        clr = (k == 0);
        if (r) begin
            m_valid[k] = 1'b1;
            e_rd[k] = 8'h00; e_rv[k] = 1'b0; e_err[k] = 1'b0; e_rdk[k] = 1'b1;
            m_left[k] = clr ? dep : 0;
            for (int i = 0; i < 32; i++) begin
                m_mem[k][i]   = 8'h00;
                m_known[k][i] = clr;
            end
        end else if (!m_valid[k]) begin
            // nothing known before the first reset
        end else if (m_left[k] > 0) begin
            m_left[k]--;
            e_rd[k] = 8'h00; e_rv[k] = 1'b0; e_err[k] = 1'b0; e_rdk[k] = 1'b1;
        end else begin
            inr      = (int'(addr) < dep);
            e_rv[k]  = re;
            e_err[k] = (re || we) && !inr;
            e_rd[k]  = 8'h00;
            e_rdk[k] = 1'b1;
            if (re && inr) begin
                if (we) e_rd[k] = wd;
                else begin
                    e_rd[k]  = m_mem[k][addr];
                    e_rdk[k] = m_known[k][addr];
                end
            end
            if (we && inr) begin
                m_mem[k][addr]   = wd;
                m_known[k][addr] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst, ifa.mem_write, ifa.mem_read, ifa.address, ifa.write_data);
        model_step(1, rst, ifb.mem_write, ifb.mem_read, ifb.address, ifb.write_data);
    end

    always @(negedge clk) begin
        if (m_valid[0]) begin
            check("a.busy", 32'(ifa.busy), 32'(m_left[0] != 0));
            check("a.read_valid", 32'(ifa.read_valid), 32'(e_rv[0]));
            check("a.addr_error", 32'(ifa.addr_error), 32'(e_err[0]));
            if (e_rdk[0]) check("a.read_data", 32'(ifa.read_data), 32'(e_rd[0]));
        end
        if (m_valid[1]) begin
            check("b.busy", 32'(ifb.busy), 32'(m_left[1] != 0));
            check("b.read_valid", 32'(ifb.read_valid), 32'(e_rv[1]));
            check("b.addr_error", 32'(ifb.addr_error), 32'(e_err[1]));
            if (e_rdk[1]) check("b.read_data", 32'(ifb.read_data), 32'(e_rd[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit we, input bit re, input logic [4:0] a, input logic [7:0] d);
        ifa.mem_write = we; ifa.mem_read = re; ifa.address = a; ifa.write_data = d;
    endtask

    task automatic set_b(input bit we, input bit re, input logic [4:0] a, input logic [7:0] d);
        ifb.mem_write = we; ifb.mem_read = re; ifb.address = a; ifb.write_data = d;
    endtask

    // Counts cycles with A busy, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (ifa.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // 1: clear takes 20 cycles, then every word reads as zero
        rst = 1'b0;
        count_busy(n);
        check("t1.busy_cycles", 32'(n), 32'd20);
        for (int a = 0; a < 20; a++) begin
            set_a(0, 1, 5'(a), 8'h00);
            tick();
            check("t1.read_valid", 32'(ifa.read_valid), 32'd1);
            check("t1.read_data", 32'(ifa.read_data), 32'h00);
        end

        // 2: back-to-back reads
        set_a(1, 0, 5'd3, 8'hA5);  tick();
        set_a(1, 0, 5'd19, 8'h5A); tick();
        set_a(0, 1, 5'd3, 8'h00);  tick();
        check("t2.rd3", 32'(ifa.read_data), 32'hA5);
        set_a(0, 1, 5'd19, 8'h00); tick();
        check("t2.rd19", 32'(ifa.read_data), 32'h5A);
        check("t2.rv19", 32'(ifa.read_valid), 32'd1);
        set_a(0, 0, 5'd0, 8'h00);  tick();
        check("t2.idle_rv", 32'(ifa.read_valid), 32'd0);
        check("t2.idle_rd", 32'(ifa.read_data), 32'h00);

        // 3: write-first bypass
        set_a(1, 0, 5'd7, 8'h11); tick();
        set_a(1, 1, 5'd7, 8'h3C); tick();
        check("t3.bypass", 32'(ifa.read_data), 32'h3C);
        set_a(0, 0, 5'd0, 8'h00); tick();
        set_a(0, 1, 5'd7, 8'h00); tick();
        check("t3.reread", 32'(ifa.read_data), 32'h3C);

        // 4: out-of-range address
        set_a(1, 0, 5'd25, 8'hFF); tick();
        check("t4.werr", 32'(ifa.addr_error), 32'd1);
        check("t4.wrv", 32'(ifa.read_valid), 32'd0);
        set_a(0, 1, 5'd25, 8'h00); tick();
        check("t4.rerr", 32'(ifa.addr_error), 32'd1);
        check("t4.rrv", 32'(ifa.read_valid), 32'd1);
        check("t4.rrd", 32'(ifa.read_data), 32'h00);
        set_a(0, 1, 5'd5, 8'h00); tick();
        check("t4.alias_err", 32'(ifa.addr_error), 32'd0);
        check("t4.alias_rd", 32'(ifa.read_data), 32'h00);

        // 5: reset mid-clear restarts the sweep; requests while busy are ignored
        set_a(0, 0, 5'd0, 8'h00);
        rst = 1'b1; tick();
        rst = 1'b0;
        set_a(1, 1, 5'd2, 8'h77);
        repeat (10) tick();
        check("t5.mid_busy", 32'(ifa.busy), 32'd1);
        check("t5.mid_rv", 32'(ifa.read_valid), 32'd0);
        rst = 1'b1; tick();
        rst = 1'b0;
        set_a(1, 1, 5'd4, 8'h99);
        count_busy(n);
        check("t5.busy_cycles", 32'(n), 32'd20);
        set_a(0, 1, 5'd4, 8'h00); tick();
        check("t5.rd4", 32'(ifa.read_data), 32'h00);
        set_a(0, 1, 5'd2, 8'h00); tick();
        check("t5.rd2", 32'(ifa.read_data), 32'h00);
        set_a(0, 1, 5'd3, 8'h00); tick();
        check("t5.rd3", 32'(ifa.read_data), 32'h00);
        set_a(0, 0, 5'd0, 8'h00);

        // 6: no-clear instance is usable straight after reset
        rst = 1'b1; tick();
        rst = 1'b0;
        check("t6.busy", 32'(ifb.busy), 32'd0);
        set_b(1, 0, 5'd31, 8'h42); tick();
        set_b(0, 1, 5'd31, 8'h00); tick();
        check("t6.rd31", 32'(ifb.read_data), 32'h42);
        check("t6.rv31", 32'(ifb.read_valid), 32'd1);
        check("t6.err", 32'(ifb.addr_error), 32'd0);
        set_b(0, 0, 5'd0, 8'h00);
        count_busy(n);
        check("t6.a_busy_cycles", 32'(n), 32'd18);
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
